// File: rtl/sort_host.sv
// sort_host: word RAM plus host-side load/order/drain sequencer for one sorter.
// Words are streamed in from address 0, one sort order is issued over the
// stored range, then the sorted words are streamed back out one per two cycles.
module sort_host #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  order_valid,
    input  logic                  order_busy,
    output logic [ADDR_WIDTH-1:0] order_start,
    output logic [DATA_WIDTH-1:0] order_len,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic                  ram_write_req,
    input  logic [DATA_WIDTH-1:0] ram_write_data,
    output logic [DATA_WIDTH-1:0] ram_read_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_C = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ONE_C  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_SORT      = 3'd2,
        ST_DRAIN_RD  = 3'd3,
        ST_DRAIN_OUT = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [DEPTH_LOG2:0]     count_r;
    logic [DEPTH_LOG2:0]     count_inc_s;
    logic [DEPTH_LOG2-1:0]   idx_r;
    logic                    seen_busy_r;
    logic [DATA_WIDTH-1:0]   out_data_r;
    logic                    out_last_r;
    logic [DATA_WIDTH-1:0]   ram_read_data_r;
    logic                    load_fire_s;
    logic                    load_last_s;
    logic                    drain_fire_s;
    logic                    in_ready_s;
    logic                    sorter_own_s;
    logic [DEPTH_LOG2-1:0]   ram_idx_s;
    logic                    unused_addr_s;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // The sorter only decodes the low address bits; the rest are don't-care.
    assign ram_idx_s     = ram_addr[DEPTH_LOG2-1:0];
    assign unused_addr_s = ^ram_addr;

    assign count_inc_s  = count_r + ONE_C;
    assign in_ready_s   = (state_r == ST_LOAD) && !count_r[DEPTH_LOG2];
    assign sorter_own_s = (state_r == ST_ISSUE) || (state_r == ST_SORT);

    assign in_ready      = in_ready_s;
    assign busy          = (state_r != ST_LOAD);
    assign out_valid     = (state_r == ST_DRAIN_OUT);
    assign out_last      = (state_r == ST_DRAIN_OUT) && out_last_r;
    assign out_data      = out_data_r;
    assign order_valid   = (state_r == ST_ISSUE);
    assign order_start   = {ADDR_WIDTH{1'b0}};
    assign order_len     = (state_r == ST_ISSUE) ?
                           {{(DATA_WIDTH-DEPTH_LOG2-1){1'b0}}, count_r} :
                           {DATA_WIDTH{1'b0}};
    assign ram_read_data = ram_read_data_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and the per-cycle strobes that drive the datapath.
    always_comb begin
        state_s      = state_r;
        load_fire_s  = 1'b0;
        load_last_s  = 1'b0;
        drain_fire_s = 1'b0;
        case (state_r)
            ST_LOAD: begin
                if (in_valid && in_ready_s) begin
                    load_fire_s = 1'b1;
                    // Explicit last and filling the RAM collapse into one last beat.
                    if (in_last || (count_inc_s == FULL_C)) begin
                        load_last_s = 1'b1;
                        // A single word is already sorted; skip the order.
                        if (|count_inc_s[DEPTH_LOG2:1]) begin
                            state_s = ST_ISSUE;
                        end else begin
                            state_s = ST_DRAIN_RD;
                        end
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_ISSUE: begin
                state_s = ST_SORT;
            end
            ST_SORT: begin
                if (seen_busy_r && !order_busy) begin
                    state_s = ST_DRAIN_RD;
                end else begin
                    state_s = ST_SORT;
                end
            end
            ST_DRAIN_RD: begin
                state_s = ST_DRAIN_OUT;
            end
            ST_DRAIN_OUT: begin
                if (out_ready) begin
                    drain_fire_s = 1'b1;
                    if (out_last_r) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_DRAIN_RD;
                    end
                end else begin
                    state_s = ST_DRAIN_OUT;
                end
            end
            default: begin
                state_s = ST_LOAD;
            end
        endcase
    end

    // Word count, drain index, sorter-busy tracking and the output beat register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= {(DEPTH_LOG2+1){1'b0}};
            idx_r       <= {DEPTH_LOG2{1'b0}};
            seen_busy_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_last_r  <= 1'b0;
        end else begin
            if (load_fire_s) begin
                count_r <= count_inc_s;
            end else if (drain_fire_s && out_last_r) begin
                count_r <= {(DEPTH_LOG2+1){1'b0}};
            end

            if (load_last_s) begin
                idx_r <= {DEPTH_LOG2{1'b0}};
            end else if (drain_fire_s && !out_last_r) begin
                idx_r <= idx_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
            end

            // The sorter may not raise busy immediately; completion is its falling edge.
            if (load_last_s) begin
                seen_busy_r <= 1'b0;
            end else if ((state_r == ST_SORT) && order_busy) begin
                seen_busy_r <= 1'b1;
            end

            if (state_r == ST_DRAIN_RD) begin
                out_data_r <= mem[idx_r];
                out_last_r <= ({1'b0, idx_r} == (count_r - ONE_C));
            end
        end
    end

    // Single-port RAM write: host during LOAD, sorter during ISSUE/SORT. Never reset.
    always_ff @(posedge clk) begin
        if (!rst && load_fire_s) begin
            mem[count_r[DEPTH_LOG2-1:0]] <= in_data;
        end else if (!rst && sorter_own_s && ram_write_req) begin
            mem[ram_idx_s] <= ram_write_data;
        end
    end

    // Sorter read port: one-cycle latency, old data on read-during-write, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_read_data_r <= {DATA_WIDTH{1'b0}};
        end else if (sorter_own_s) begin
            ram_read_data_r <= mem[ram_idx_s];
        end
    end

endmodule

// File: tb/tb_sort_host.sv
// Bench for sort_host: plays the sorter on the RAM/order side and the stream
// producer/consumer on the host side; expected output is the sorted input.
module tb_sort_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'd0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        order_valid;
    logic        order_busy = 1'b0;
    logic [15:0] order_start;
    logic [15:0] order_len;
    logic [15:0] ram_addr = 16'd0;
    logic        ram_write_req = 1'b0;
    logic [15:0] ram_write_data = 16'd0;
    logic [15:0] ram_read_data;

    int n_tests = 0;
    int n_fail  = 0;
    int ov_pulses = 0;

    sort_host #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH_LOG2(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .order_valid(order_valid), .order_busy(order_busy),
        .order_start(order_start), .order_len(order_len),
        .ram_addr(ram_addr), .ram_write_req(ram_write_req),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Count order pulses away from the active edge.
    always @(negedge clk) begin
        if (order_valid) ov_pulses++;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full job: load, (sort), drain; optional reset while sorting and a
    // forced sorter write during LOAD that must be ignored.
    task automatic run_job(input int words[$], input int exp[$], input bit use_last,
                           input bit stall, input bit poke, input bit rst_in_sort);
        int n, i, guard, got, first_valid, lat, p0;
        bit acc, prev_stall, rdy, poked;
        logic [15:0] held, rd0;
        int q[$];
        n = words.size();
        i = 0; guard = 0; poked = 1'b0;
        p0 = ov_pulses;
        while (i < n && guard < 4000) begin
            if (poke && i == 1 && !poked) begin
                in_valid = 1'b0;
                ram_write_req = 1'b1; ram_addr = 16'd0; ram_write_data = 16'd999;
                rd0 = ram_read_data;
                step();
                chk("ram_read_hold_in_load", ram_read_data, rd0);
                ram_write_req = 1'b0;
                poked = 1'b1;
            end else if (stall && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                step();
            end else begin
                in_valid = 1'b1;
                in_data  = 16'(words[i]);
                in_last  = use_last && (i == n - 1);
                acc = in_ready;
                step();
                if (acc) i++;
            end
            guard++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        if (i < n) chk("load_timeout", i, n);
        chk("in_ready_after_last", in_ready, 1'b0);

        if (n >= 2) begin
            chk("order_valid_issue", order_valid, 1'b1);
            chk("order_len", order_len, n);
            chk("order_start", order_start, 0);
            order_busy = 1'b1;
            in_valid = 1'b1; in_data = 16'h0123;   // must be held off
            step();
            chk("order_valid_one_cycle", order_valid, 1'b0);
            chk("in_ready_in_sort", in_ready, 1'b0);
            chk("busy_in_sort", busy, 1'b1);
            for (int k = 0; k < n; k++) begin
                ram_addr = 16'(k);
                step();
                q.push_back(int'(ram_read_data));
            end
            if (rst_in_sort) begin
                rst = 1'b1;
                step();
                rst = 1'b0; in_valid = 1'b0; order_busy = 1'b0;
                chk("rst_busy", busy, 1'b0);
                chk("rst_in_ready", in_ready, 1'b1);
                chk("rst_out_valid", out_valid, 1'b0);
                chk("rst_order_valid", order_valid, 1'b0);
                return;
            end
            q.sort();
            for (int k = 0; k < n; k++) begin
                ram_write_req = 1'b1; ram_addr = 16'(k); ram_write_data = 16'(q[k]);
                step();
            end
            ram_write_req = 1'b0;
            chk("still_sorting", out_valid, 1'b0);
            order_busy = 1'b0;
            in_valid = 1'b0;
            lat = 2;
        end else begin
            chk("no_order_single", order_valid, 1'b0);
            lat = 1;
        end
        chk("order_pulses", ov_pulses - p0, (n >= 2) ? 1 : 0);

        got = 0; guard = 0; first_valid = -1; prev_stall = 1'b0; held = 16'd0;
        while (got < n && guard < 4000) begin
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            if (out_valid && first_valid < 0) begin
                first_valid = guard;
                chk("first_valid_latency", first_valid, lat);
            end
            if (prev_stall) begin
                chk("stall_valid_held", out_valid, 1'b1);
                chk("stall_data_held", out_data, held);
            end
            if (out_valid) begin
                if (rdy) begin
                    chk("out_data", out_data, exp[got]);
                    chk("out_last", out_last, got == n - 1);
                    got++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    held = out_data;
                end
            end
            step();
            guard++;
        end
        out_ready = 1'b0;
        if (got < n) chk("drain_timeout", got, n);
        chk("back_to_load_busy", busy, 1'b0);
        chk("back_to_load_in_ready", in_ready, 1'b1);
        chk("back_to_load_out_valid", out_valid, 1'b0);
    endtask

    typedef struct {
        int n;
        int w[4];
        int e[4];
        bit use_last;
        bit stall;
        bit poke;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int words[$];
        int exp[$];
        int len;

        tbl[0] = '{4, '{5, 3, 9, 1}, '{1, 3, 5, 9}, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1, '{7, 0, 0, 0}, '{7, 0, 0, 0}, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{4, '{2, 4, 8, 4}, '{2, 4, 4, 8}, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{2, '{6, 2, 0, 0}, '{2, 6, 0, 0}, 1'b1, 1'b0, 1'b0};

        // Reset state.
        step();
        step();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_data", out_data, 0);
        chk("rst_order_valid", order_valid, 1'b0);
        chk("rst_order_start", order_start, 0);
        chk("rst_order_len", order_len, 0);
        chk("rst_ram_read_data", ram_read_data, 0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        step();

        // Directed table.
        for (int t = 0; t < 4; t++) begin
            words.delete(); exp.delete();
            for (int k = 0; k < tbl[t].n; k++) begin
                words.push_back(tbl[t].w[k]);
                exp.push_back(tbl[t].e[k]);
            end
            run_job(words, exp, tbl[t].use_last, tbl[t].stall, tbl[t].poke, 1'b0);
        end

        // Reset during SORT, then a fresh load 6, 2.
        words = '{3, 1, 2};
        exp = '{1, 2, 3};
        run_job(words, exp, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        words = '{6, 2};
        exp = '{2, 6};
        run_job(words, exp, 1'b1, 1'b0, 1'b0, 1'b0);

        // Full RAM: implicit last, then in_last coinciding with full.
        for (int pass = 0; pass < 2; pass++) begin
            words.delete();
            for (int k = 0; k < 256; k++) words.push_back(int'($urandom_range(0, 32767)));
            exp = words;
            exp.sort();
            run_job(words, exp, pass == 1, 1'b0, 1'b0, 1'b0);
        end

        // Random jobs against the sorted-copy reference.
        for (int r = 0; r < 10; r++) begin
            len = int'($urandom_range(1, 12));
            words.delete();
            for (int k = 0; k < len; k++) words.push_back(int'($urandom_range(0, 40)));
            exp = words;
            exp.sort();
            run_job(words, exp, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
